multi_chan_accum: RTL

Parametrised multi-channel accumulator replacing the single combinational 8-bit adder at the top of the design. It takes a stream of (channel, opcode, operand) requests over a valid/ready handshake and updates one of CHANNELS accumulator registers per accepted request. It returns the updated value through a one-entry registered output with its own handshake. It sits between the `ui_in`/`uio_in` pin decode and the `uo_out` driver in `tt_um_example`.

---
 rtl/mca_pkg.sv | 19 +
 rtl/multi_chan_accum_if.sv | 33 +++
 rtl/mca_alu.sv | 49 ++++
 rtl/multi_chan_accum.sv | 112 +++++++++++
 4 files changed

// File: rtl/mca_pkg.sv
// Shared opcode definitions for the multi-channel accumulator and its pin decode.
package mca_pkg;

    localparam int MCA_OP_W = 2;

    typedef enum logic [MCA_OP_W-1:0] {
        MCA_ADD  = 2'd0,
        MCA_SUB  = 2'd1,
        MCA_LOAD = 2'd2,
        MCA_READ = 2'd3
    } mca_op_e;

    // Raw encodings for the ui_in/uio_in decode, which works on plain bit fields.
    localparam logic [MCA_OP_W-1:0] MCA_OP_ADD  = 2'd0;
    localparam logic [MCA_OP_W-1:0] MCA_OP_SUB  = 2'd1;
    localparam logic [MCA_OP_W-1:0] MCA_OP_LOAD = 2'd2;
    localparam logic [MCA_OP_W-1:0] MCA_OP_READ = 2'd3;

endpackage

// File: rtl/multi_chan_accum_if.sv
// Request/result handshake bundle for multi_chan_accum; slave is the accumulator side.
interface multi_chan_accum_if
    import mca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHANNELS  = 4
);
    localparam int CHAN_W = $clog2(CHANNELS);

    logic                 in_valid;
    logic                 in_ready;
    logic [CHAN_W-1:0]    in_chan;
    mca_op_e              in_op;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CHAN_W-1:0]    out_chan;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_ovf;
    logic                 out_sticky;

    modport master (
        output in_valid, in_chan, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_chan, out_acc, out_ovf, out_sticky
    );

    modport slave (
        input  in_valid, in_chan, in_op, in_data, out_ready,
        output in_ready, out_valid, out_chan, out_acc, out_ovf, out_sticky
    );

endinterface

// File: rtl/mca_alu.sv
// Combinational accumulator datapath. Define MCA_SATURATE_EN to clamp on
// overflow/underflow instead of wrapping.
module mca_alu
    import mca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]     data,
    input  mca_op_e              op,
    output logic [ACC_WIDTH-1:0] acc_next,
    output logic                 ovf
);
    // One extra bit so the carry/borrow falls out of the top of the result.
    logic [ACC_WIDTH:0] data_ext;
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] diff;

    assign data_ext = (ACC_WIDTH+1)'(data);
    assign sum      = {1'b0, acc} + data_ext;
    assign diff     = {1'b0, acc} - data_ext;

    always_comb begin
        acc_next = acc;
        ovf      = 1'b0;
        case (op)
            MCA_ADD: begin
                ovf = sum[ACC_WIDTH];
`ifdef MCA_SATURATE_EN
                acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
                acc_next = sum[ACC_WIDTH-1:0];
`endif
            end
            MCA_SUB: begin
                ovf = diff[ACC_WIDTH];
`ifdef MCA_SATURATE_EN
                acc_next = diff[ACC_WIDTH] ? '0 : diff[ACC_WIDTH-1:0];
`else
                acc_next = diff[ACC_WIDTH-1:0];
`endif
            end
            MCA_LOAD: acc_next = data_ext[ACC_WIDTH-1:0];
            default:  acc_next = acc;
        endcase
    end

endmodule

// File: rtl/multi_chan_accum.sv
// Multi-channel accumulator: per-channel register file and sticky flags, one-entry
// registered result buffer. Saturation is selected by MCA_SATURATE_EN (see mca_alu).
module multi_chan_accum
    import mca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHANNELS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    multi_chan_accum_if.slave  bus
);
    localparam int              CHAN_W     = $clog2(CHANNELS);
    localparam logic [CHAN_W:0] CHAN_LIMIT = (CHAN_W+1)'(CHANNELS);

    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_vec;
    logic [CHANNELS-1:0]                sticky_vec;

    logic                 accept;
    logic                 chan_ok;
    logic                 do_update;
    logic [ACC_WIDTH-1:0] sel_acc;
    logic                 sel_sticky;
    logic [ACC_WIDTH-1:0] alu_acc;
    logic                 alu_ovf;
    logic                 sticky_next;

    logic                 out_valid_reg;
    logic [CHAN_W-1:0]    out_chan_reg;
    logic [ACC_WIDTH-1:0] out_acc_reg;
    logic                 out_ovf_reg;
    logic                 out_sticky_reg;

    // Ready depends only on the output buffer, never on in_valid.
    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign chan_ok      = {1'b0, bus.in_chan} < CHAN_LIMIT;
    assign do_update    = accept && chan_ok;

    always_comb begin
        sel_acc    = '0;
        sel_sticky = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_chan == CHAN_W'(i)) begin
                sel_acc    = acc_vec[i];
                sel_sticky = sticky_vec[i];
            end
        end
    end

    mca_alu #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_alu (
        .acc      (sel_acc),
        .data     (bus.in_data),
        .op       (bus.in_op),
        .acc_next (alu_acc),
        .ovf      (alu_ovf)
    );

    assign sticky_next = (bus.in_op == MCA_LOAD) ? 1'b0 : (sel_sticky | alu_ovf);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [ACC_WIDTH-1:0] acc_reg;
        logic                 sticky_reg;
        logic                 wr_en;

        assign wr_en = do_update && (bus.in_chan == CHAN_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_reg    <= '0;
                sticky_reg <= 1'b0;
            end else if (wr_en) begin
                acc_reg    <= alu_acc;
                sticky_reg <= sticky_next;
            end
        end

        assign acc_vec[gi]    = acc_reg;
        assign sticky_vec[gi] = sticky_reg;
    end

    // A dropped (out-of-range) request still consumes the handshake, so it may
    // retire a pending result but never produces one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_chan_reg   <= '0;
            out_acc_reg    <= '0;
            out_ovf_reg    <= 1'b0;
            out_sticky_reg <= 1'b0;
        end else if (do_update) begin
            out_valid_reg  <= 1'b1;
            out_chan_reg   <= bus.in_chan;
            out_acc_reg    <= alu_acc;
            out_ovf_reg    <= alu_ovf;
            out_sticky_reg <= sticky_next;
        end else if (bus.out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_chan   = out_chan_reg;
    assign bus.out_acc    = out_acc_reg;
    assign bus.out_ovf    = out_ovf_reg;
    assign bus.out_sticky = out_sticky_reg;

endmodule
